// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Multi-cycle MULT/MULTU/DIV/DIVU unit holding the HI/LO registers,
//            with MTHI/MTLO writes while idle.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] c_mult_cnt = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] c_div_cnt  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] c_one      = CW'(1);

    localparam logic [2:0] c_op_mult  = 3'd1;
    localparam logic [2:0] c_op_multu = 3'd2;
    localparam logic [2:0] c_op_div   = 3'd3;
    localparam logic [2:0] c_op_divu  = 3'd4;
    localparam logic [2:0] c_op_mthi  = 3'd5;
    localparam logic [2:0] c_op_mtlo  = 3'd6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_count;
    logic [31:0]    r_pend_hi;
    logic [31:0]    r_pend_lo;
    logic           r_pend_skip;

    // Products: both operands widened to 64 bits, low 64 bits of the product kept
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly
    logic        w_is_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_num;
    logic [31:0] w_den;
    logic [31:0] w_den_safe;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_launch;

    assign w_is_signed = (op == c_op_div);
    assign w_a_neg     = w_is_signed & A[31];
    assign w_b_neg     = w_is_signed & B[31];
    assign w_num       = w_a_neg ? (~A + 32'd1) : A;
    assign w_den       = w_b_neg ? (~B + 32'd1) : B;
    assign w_den_safe  = (B == 32'd0) ? 32'd1 : w_den;
    assign w_q         = w_num / w_den_safe;
    assign w_r         = w_num % w_den_safe;
    assign w_quo       = (w_a_neg ^ w_b_neg) ? (~w_q + 32'd1) : w_q;
    assign w_rem       = w_a_neg ? (~w_r + 32'd1) : w_r;

    assign w_launch = start && (op >= c_op_mult) && (op <= c_op_divu);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            busy        <= 1'b0;
            HI          <= 32'd0;
            LO          <= 32'd0;
            r_pend_hi   <= 32'd0;
            r_pend_lo   <= 32'd0;
            r_pend_skip <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_state <= S_RUN;
                        busy    <= 1'b1;
                        if (op == c_op_mult || op == c_op_multu) begin
                            r_count     <= c_mult_cnt;
                            r_pend_skip <= 1'b0;
                            {r_pend_hi, r_pend_lo} <= (op == c_op_mult) ? w_prod_s : w_prod_u;
                        end else begin
                            r_count     <= c_div_cnt;
                            r_pend_skip <= (B == 32'd0);
                            r_pend_hi   <= w_rem;
                            r_pend_lo   <= w_quo;
                        end
                    end else if (op == c_op_mthi) begin
                        HI <= A;
                    end else if (op == c_op_mtlo) begin
                        LO <= A;
                    end
                end
                S_RUN: begin
                    r_count <= r_count - c_one;
                    if (r_count == c_one) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        // Divide by zero runs its full latency but leaves HI/LO alone
                        if (!r_pend_skip) begin
                            HI <= r_pend_hi;
                            LO <= r_pend_lo;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Directed plus random stimulus for mult_div_unit against a
//            plain-arithmetic reference model of HI/LO and busy latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .HI   (HI),
        .LO   (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: new HI/LO from plain 64-bit arithmetic
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] hi, inout logic [31:0] lo);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        case (o)
            3'd1: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                hi = p[63:32];
                lo = p[31:0];
            end
            3'd2: begin
                p  = {32'd0, a} * {32'd0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            3'd3: if (b != 32'd0) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                sq = sa / sb;
                sr = sa % sb;
                lo = sq[31:0];
                hi = sr[31:0];
            end
            3'd4: if (b != 32'd0) begin
                lo = a / b;
                hi = a % b;
            end
            default: ;
        endcase
    endtask

    // Launch an op at the current negedge and follow it until busy drops
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit collide);
        int          cycles;
        int          n;
        logic [31:0] nh, nl;
        nh = m_hi;
        nl = m_lo;
        model(o, a, b, nh, nl);
        n = (o <= 3'd2) ? MULT_N : DIV_N;
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            check("hold_hi", HI, m_hi);
            check("hold_lo", LO, m_lo);
            if (collide && cycles == 1) begin
                start = 1'b1; op = 3'd3; A = $urandom; B = 32'd3;
            end else if (collide && cycles == 2) begin
                start = 1'b0; op = 3'd5; A = 32'hDEAD;
            end else if (collide && cycles == 3) begin
                op = 3'd0;
            end
            @(negedge clk);
            cycles++;
        end
        check("busy_len", 32'(cycles), 32'(n));
        m_hi = nh;
        m_lo = nl;
        check("res_hi", HI, m_hi);
        check("res_lo", LO, m_lo);
    endtask

    // Single-cycle idle op (MTHI/MTLO or a no-op code), start level arbitrary
    task automatic idle_op(input logic [2:0] o, input logic [31:0] a);
        start = 1'($urandom_range(0, 1));
        op = o; A = a; B = $urandom;
        if (o == 3'd5) m_hi = a;
        if (o == 3'd6) m_lo = a;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_hi", HI, m_hi);
        check("idle_lo", LO, m_lo);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        reset = 1'b0;

        // Reset mid-MULT: discards the op and clears HI/LO
        idle_op(3'd5, 32'hAAAA5555);
        idle_op(3'd6, 32'h1234ABCD);
        start = 1'b1; op = 3'd1; A = 32'd5; B = 32'd6;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", HI, 32'd0);
        check("midrst_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (8) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_hi", HI, 32'd0);
        check("post_rst_lo", LO, 32'd0);

        // Directed arithmetic cases with literal expectations as well
        do_op(3'd1, 32'hFFFFFFFD, 32'd7, 1'b0);
        check("mult_hi_k", HI, 32'hFFFFFFFF);
        check("mult_lo_k", LO, 32'hFFFFFFEB);
        do_op(3'd2, 32'hFFFFFFFD, 32'd7, 1'b0);
        check("multu_hi_k", HI, 32'h00000006);
        check("multu_lo_k", LO, 32'hFFFFFFEB);
        do_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("div_lo_k", LO, 32'hFFFFFFFD);
        check("div_hi_k", HI, 32'hFFFFFFFF);
        do_op(3'd4, 32'd7, 32'd2, 1'b0);
        check("divu_lo_k", LO, 32'd3);
        check("divu_hi_k", HI, 32'd1);
        do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("divov_lo_k", LO, 32'h80000000);
        check("divov_hi_k", HI, 32'd0);

        // Divide by zero keeps the preloaded values
        idle_op(3'd5, 32'h11);
        idle_op(3'd6, 32'h22);
        do_op(3'd4, 32'd5, 32'd0, 1'b0);
        check("dz_hi_k", HI, 32'h11);
        check("dz_lo_k", LO, 32'h22);
        do_op(3'd3, 32'hFFFFFF00, 32'd0, 1'b0);

        // Collisions while busy, then MTLO when idle
        do_op(3'd1, 32'h00012345, 32'hFFFF0003, 1'b1);
        do_op(3'd4, 32'hCAFEBABE, 32'd1000, 1'b1);
        idle_op(3'd6, 32'd9);
        check("mtlo_k", LO, 32'd9);
        idle_op(3'd0, 32'h5A5A5A5A);
        idle_op(3'd7, 32'hA5A5A5A5);

        // Back-to-back launches on the first idle cycle
        do_op(3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
        do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        do_op(3'd3, 32'd100, 32'hFFFFFFF9, 1'b0);

        // Random mix
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  o;
            logic [31:0] a, b;
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if (o >= 3'd1 && o <= 3'd4) do_op(o, a, b, 1'($urandom_range(0, 1)));
            else idle_op(o, a);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
